// File: rtl/d_hazard_unit_pkg.sv
// Shared RISC-V opcode header (opcode[6:2] values and decode helpers) plus the
// scoreboard entry type used by the decode-stage hazard unit.
`ifndef RV_OPCODES_DEFINES
`define RV_OPCODES_DEFINES
`define OPC_LOAD_5   5'b00000
`define OPC_OP_IMM_5 5'b00100
`define OPC_AUIPC_5  5'b00101
`define OPC_STORE_5  5'b01000
`define OPC_OP_5     5'b01100
`define OPC_LUI_5    5'b01101
`define OPC_BRANCH_5 5'b11000
`define OPC_JALR_5   5'b11001
`define OPC_JAL_5    5'b11011

// Decode helpers; the argument must be a plain instruction signal name.
`define IS_WRITER(inst) ((inst[6:2] != `OPC_BRANCH_5) && (inst[6:2] != `OPC_STORE_5) && (inst[11:7] != 5'd0))
`define USES_RS1(inst)  ((inst[6:2] != `OPC_LUI_5) && (inst[6:2] != `OPC_AUIPC_5) && (inst[6:2] != `OPC_JAL_5))
`define USES_RS2(inst)  ((inst[6:2] == `OPC_OP_5) || (inst[6:2] == `OPC_BRANCH_5) || (inst[6:2] == `OPC_STORE_5))
`endif

package d_hazard_unit_pkg;

  localparam int MAX_NSTAGES = 6;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

endpackage

// File: rtl/d_hazard_unit_hazard_src_match.sv
// Scans the scoreboard for the youngest in-flight writer of one source register
// and reports either a forwarding stage or that the value is not yet available.
module hazard_src_match
  import d_hazard_unit_pkg::*;
#(
  parameter int NSTAGES    = 2,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int SELW       = 2
) (
  input  logic [4:0]              src_i,
  input  logic                    use_i,
  input  sb_entry_t [NSTAGES-1:0] sb_i,
  output logic [SELW-1:0]         sel_o,
  output logic                    not_ready_o
);

  logic [SELW-1:0] hit_stage;
  logic            hit_load;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    hit_stage   = '0;
    hit_load    = 1'b0;
    sel_o       = '0;
    not_ready_o = 1'b0;

    // Walk oldest to youngest so the lowest-index match is the one kept.
    for (int k = NSTAGES; k >= 1; k--) begin
      if (sb_i[k-1].valid && (sb_i[k-1].rd == src_i)) begin
        hit_stage = SELW'(k);
        hit_load  = sb_i[k-1].is_load;
      end
    end

    if (use_i && (src_i != 5'd0) && (hit_stage != '0)) begin
      if (int'(hit_stage) >= (hit_load ? LOAD_READY : ALU_READY)) begin
        sel_o = hit_stage;
      end else begin
        not_ready_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/d_hazard_unit.sv
// Decode-stage hazard unit: in-flight destination scoreboard, per-source forwarding
// selects, load-use stall and a multi-cycle decode squash after a redirect.
module d_hazard_unit
  import d_hazard_unit_pkg::*;
#(
  parameter  int NSTAGES    = 2,
  parameter  int ALU_READY  = 1,
  parameter  int LOAD_READY = 2,
  parameter  int FLUSH_LEN  = 1,
  localparam int SELW       = $clog2(NSTAGES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_valid,
  input  logic [31:0]        d_inst,
  input  logic               redirect,
  input  logic               hold,
  output logic [SELW-1:0]    fwd_sel_rs1,
  output logic [SELW-1:0]    fwd_sel_rs2,
  output logic               stall,
  output logic               nop_sel,
  output logic [NSTAGES-1:0] sb_busy
);

  localparam int                CNT_W        = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_LEN - 1);

  sb_entry_t [NSTAGES-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  sb_entry_t               dec_entry;
  logic                    nr_rs1, nr_rs2;
  logic                    unused_inst_bits;

  // Funct fields and the compressed-size bits do not affect hazards.
  assign unused_inst_bits = ^{d_inst[31:25], d_inst[14:12], d_inst[1:0]};

  hazard_src_match #(
    .NSTAGES   (NSTAGES),
    .ALU_READY (ALU_READY),
    .LOAD_READY(LOAD_READY),
    .SELW      (SELW)
  ) u_match_rs1 (
    .src_i      (d_inst[19:15]),
    .use_i      (`USES_RS1(d_inst)),
    .sb_i       (sb_q),
    .sel_o      (fwd_sel_rs1),
    .not_ready_o(nr_rs1)
  );

  hazard_src_match #(
    .NSTAGES   (NSTAGES),
    .ALU_READY (ALU_READY),
    .LOAD_READY(LOAD_READY),
    .SELW      (SELW)
  ) u_match_rs2 (
    .src_i      (d_inst[24:20]),
    .use_i      (`USES_RS2(d_inst)),
    .sb_i       (sb_q),
    .sel_o      (fwd_sel_rs2),
    .not_ready_o(nr_rs2)
  );

  // A squashed decode slot never stalls: the redirect takes priority.
  assign nop_sel = redirect | (cnt_q != '0);
  assign stall   = ~nop_sel & (nr_rs1 | nr_rs2);

  always_comb begin
    dec_entry.valid   = d_valid & ~stall & ~nop_sel & `IS_WRITER(d_inst);
    dec_entry.rd      = d_inst[11:7];
    dec_entry.is_load = (d_inst[6:2] == `OPC_LOAD_5);

    sb_d[0] = dec_entry;
    for (int k = 1; k < NSTAGES; k++) begin
      sb_d[k] = sb_q[k-1];
    end

    // A redirect restarts the squash window rather than extending it.
    cnt_d = cnt_q;
    if (redirect) begin
      cnt_d = FLUSH_RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: the scoreboard is a handful of flops, not a RAM, so it is reset to make every valid bit defined.
      sb_q  <= '0;
      cnt_q <= '0;
    end else if (!hold) begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    sb_busy = '0;
    for (int k = 0; k < NSTAGES; k++) begin
      sb_busy[k] = sb_q[k].valid;
    end
  end

endmodule

// File: tb/tb_d_hazard_unit.sv
// Bench for d_hazard_unit: a default instance and a 4-stage/3-cycle-flush instance
// share directed stimulus; an age-indexed pipeline model is compared every cycle.
module tb_d_hazard_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_valid = 1'b0;
  logic [31:0] d_inst = 32'h0000_0013;
  logic        redirect = 1'b0;
  logic        hold = 1'b0;

  logic [1:0] a_s1, a_s2;
  logic       a_st, a_nop;
  logic [1:0] a_busy;
  logic [2:0] b_s1, b_s2;
  logic       b_st, b_nop;
  logic [3:0] b_busy;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  d_hazard_unit u_a (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_inst(d_inst), .redirect(redirect), .hold(hold),
    .fwd_sel_rs1(a_s1), .fwd_sel_rs2(a_s2), .stall(a_st), .nop_sel(a_nop), .sb_busy(a_busy)
  );

  d_hazard_unit #(.NSTAGES(4), .ALU_READY(1), .LOAD_READY(3), .FLUSH_LEN(3)) u_b (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_inst(d_inst), .redirect(redirect), .hold(hold),
    .fwd_sel_rs1(b_s1), .fwd_sel_rs2(b_s2), .stall(b_st), .nop_sel(b_nop), .sb_busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       ld;
  } ment_t;

  localparam int P_N  [2] = '{2, 4};
  localparam int P_AR [2] = '{1, 1};
  localparam int P_LR [2] = '{2, 3};
  localparam int P_FL [2] = '{1, 3};

  ment_t pipe [2][6];   // pipe[u][age-1]: instruction that left decode 'age' cycles ago
  int    mcnt [2];

  function automatic bit m_writer(input logic [31:0] i);
    return (i[6:0] != 7'b1100011) && (i[6:0] != 7'b0100011) && (i[11:7] != 5'd0);
  endfunction

  function automatic bit m_use1(input logic [31:0] i);
    return !(i[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
  endfunction

  function automatic bit m_use2(input logic [31:0] i);
    return i[6:0] inside {7'b0110011, 7'b1100011, 7'b0100011};
  endfunction

  function automatic void m_src(input int u, input logic [4:0] src, input bit used,
                                output int sel, output bit nr);
    bit found = 1'b0;
    sel = 0;
    nr  = 1'b0;
    if (used && src != 5'd0) begin
      for (int k = 0; k < P_N[u]; k++) begin
        if (!found && pipe[u][k].v && pipe[u][k].rd == src) begin
          found = 1'b1;
          if (k + 1 >= (pipe[u][k].ld ? P_LR[u] : P_AR[u])) sel = k + 1;
          else nr = 1'b1;
        end
      end
    end
  endfunction

  function automatic void m_eval(input int u, output int s1, output int s2,
                                 output bit st, output bit nop, output int busy);
    bit nr1, nr2;
    m_src(u, d_inst[19:15], m_use1(d_inst), s1, nr1);
    m_src(u, d_inst[24:20], m_use2(d_inst), s2, nr2);
    nop  = redirect || (mcnt[u] != 0);
    st   = !nop && (nr1 || nr2);
    busy = 0;
    for (int k = 0; k < P_N[u]; k++) if (pipe[u][k].v) busy |= (1 << k);
  endfunction

  function automatic void m_step(input int u, input bit st, input bit nop);
    ment_t e;
    if (rst) begin
      for (int k = 0; k < 6; k++) pipe[u][k] = '0;
      mcnt[u] = 0;
    end else if (!hold) begin
      e.v  = d_valid && !st && !nop && m_writer(d_inst);
      e.rd = d_inst[11:7];
      e.ld = (d_inst[6:0] == 7'b0000011);
      for (int k = P_N[u] - 1; k >= 1; k--) pipe[u][k] = pipe[u][k-1];
      pipe[u][0] = e;
      if (redirect) mcnt[u] = P_FL[u] - 1;
      else if (mcnt[u] > 0) mcnt[u] = mcnt[u] - 1;
    end
  endfunction

  always @(negedge clk) begin : compare
    int s1, s2, busy;
    bit st, nop;
    m_eval(0, s1, s2, st, nop, busy);
    if (armed) begin
      check("a fwd_sel_rs1", 32'(a_s1), s1);
      check("a fwd_sel_rs2", 32'(a_s2), s2);
      check("a stall", 32'(a_st), 32'(st));
      check("a nop_sel", 32'(a_nop), 32'(nop));
      check("a sb_busy", 32'(a_busy), busy);
    end
    m_step(0, st, nop);
    m_eval(1, s1, s2, st, nop, busy);
    if (armed) begin
      check("b fwd_sel_rs1", 32'(b_s1), s1);
      check("b fwd_sel_rs2", 32'(b_s2), s2);
      check("b stall", 32'(b_st), 32'(st));
      check("b nop_sel", 32'(b_nop), 32'(nop));
      check("b sb_busy", 32'(b_busy), busy);
    end
    m_step(1, st, nop);
    if (rst) armed = 1'b1;
  end

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] i_add(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_addi(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] i_lw(input int rd, input int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] i_sw(input int rs2, input int rs1, input int imm5);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'(imm5), 7'b0100011};
  endfunction
  function automatic logic [31:0] i_beq(input int rs1, input int rs2, input int lo5);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(lo5), 7'b1100011};
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;

  // One decode cycle: drive after the rising edge, return just after the falling edge.
  task automatic cyc(input logic [31:0] inst, input bit v, input bit rdr = 1'b0,
                     input bit hld = 1'b0, input bit rs = 1'b0);
    @(posedge clk);
    #1;
    d_inst   = inst;
    d_valid  = v;
    redirect = rdr;
    hold     = hld;
    rst      = rs;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(NOP, 1'b0);
  endtask

  initial begin
    cyc(NOP, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(NOP, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset a_busy", 32'(a_busy), 0);
    check("reset b_busy", 32'(b_busy), 0);
    check("reset a_sel", 32'(a_s1), 0);
    check("reset a_nop", 32'(a_nop), 0);

    // Back-to-back ALU
    cyc(i_addi(5, 0, 1), 1'b1);
    cyc(i_add(6, 5, 5), 1'b1);
    check("alu a_rs1", 32'(a_s1), 1);
    check("alu a_rs2", 32'(a_s2), 1);
    check("alu a_stall", 32'(a_st), 0);
    check("alu b_rs1", 32'(b_s1), 1);
    cyc(i_add(7, 5, 0), 1'b1);
    check("alu+1 a_rs1", 32'(a_s1), 2);
    check("alu+1 a_rs2", 32'(a_s2), 0);
    check("alu+1 b_rs1", 32'(b_s1), 2);
    idle(4);

    // Load-use
    cyc(i_lw(7, 2), 1'b1);
    cyc(i_add(8, 7, 1), 1'b1);
    check("lu a_stall", 32'(a_st), 1);
    check("lu a_rs1", 32'(a_s1), 0);
    check("lu b_stall", 32'(b_st), 1);
    cyc(i_add(8, 7, 1), 1'b1);
    check("lu+1 a_stall", 32'(a_st), 0);
    check("lu+1 a_rs1", 32'(a_s1), 2);
    check("lu+1 a_busy", 32'(a_busy), 2);
    check("lu+1 b_stall", 32'(b_st), 1);
    check("lu+1 b_rs1", 32'(b_s1), 0);
    cyc(i_add(8, 7, 1), 1'b1);
    check("lu+2 b_rs1", 32'(b_s1), 3);
    check("lu+2 b_stall", 32'(b_st), 0);
    idle(4);

    // x0 and non-writers (store/branch carry 9 in bits [11:7])
    cyc(i_sw(9, 2, 9), 1'b1);
    cyc(i_addi(10, 9, 0), 1'b1);
    check("sw a_rs1", 32'(a_s1), 0);
    check("sw a_busy", 32'(a_busy), 0);
    cyc(i_beq(9, 9, 9), 1'b1);
    check("beq a_rs1", 32'(a_s1), 0);
    check("beq a_rs2", 32'(a_s2), 0);
    cyc(i_addi(0, 0, 5), 1'b1);
    cyc(i_add(11, 9, 0), 1'b1);
    check("x0 a_busy", 32'(a_busy), 0);
    check("x0 b_busy", 32'(b_busy), 4);
    check("x0 a_rs1", 32'(a_s1), 0);
    cyc(i_add(12, 0, 0), 1'b1);
    check("x0 src a_rs1", 32'(a_s1), 0);
    check("x0 src a_rs2", 32'(a_s2), 0);
    idle(4);

    // Redirect: single pulse, then a second pulse in cycle 2
    cyc(i_add(13, 1, 1), 1'b1, 1'b1);
    check("rd1 a_nop", 32'(a_nop), 1);
    check("rd1 b_nop", 32'(b_nop), 1);
    cyc(i_add(13, 1, 1), 1'b1);
    check("rd2 a_nop", 32'(a_nop), 0);
    check("rd2 b_nop", 32'(b_nop), 1);
    cyc(i_add(13, 1, 1), 1'b1);
    check("rd3 b_nop", 32'(b_nop), 1);
    cyc(i_add(13, 1, 1), 1'b1);
    check("rd4 b_nop", 32'(b_nop), 0);
    check("rd4 b_busy", 32'(b_busy), 0);
    cyc(NOP, 1'b0, 1'b1);
    check("rr1 b_nop", 32'(b_nop), 1);
    cyc(NOP, 1'b0, 1'b1);
    check("rr2 b_nop", 32'(b_nop), 1);
    cyc(NOP, 1'b0);
    check("rr3 b_nop", 32'(b_nop), 1);
    cyc(NOP, 1'b0);
    check("rr4 b_nop", 32'(b_nop), 1);
    cyc(NOP, 1'b0);
    check("rr5 b_nop", 32'(b_nop), 0);

    // Stall and redirect together: redirect wins
    cyc(i_lw(7, 2), 1'b1);
    cyc(i_add(8, 7, 1), 1'b1, 1'b1);
    check("sr a_nop", 32'(a_nop), 1);
    check("sr a_stall", 32'(a_st), 0);
    check("sr b_stall", 32'(b_st), 0);
    idle(4);

    // Same rd in stages 2 (ALU) and 4 (load)
    cyc(i_lw(14, 2), 1'b1);
    idle(1);
    cyc(i_addi(14, 0, 2), 1'b1);
    idle(1);
    cyc(i_add(15, 14, 14), 1'b1);
    check("dup b_rs1", 32'(b_s1), 2);
    check("dup b_rs2", 32'(b_s2), 2);
    check("dup b_busy", 32'(b_busy), 10);
    check("dup a_rs1", 32'(a_s1), 2);
    idle(4);

    // Hold mid-flush
    cyc(i_addi(16, 0, 1), 1'b1);
    cyc(NOP, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(i_add(17, 16, 16), 1'b1, 1'b0, 1'b1);
      check("hold b_busy", 32'(b_busy), 2);
      check("hold b_nop", 32'(b_nop), 1);
      check("hold a_busy", 32'(a_busy), 2);
    end
    cyc(i_add(17, 16, 16), 1'b1);
    check("rel1 b_nop", 32'(b_nop), 1);
    check("rel1 b_busy", 32'(b_busy), 2);
    cyc(i_add(17, 16, 16), 1'b1);
    check("rel2 b_nop", 32'(b_nop), 1);
    check("rel2 b_busy", 32'(b_busy), 4);
    cyc(i_add(17, 16, 16), 1'b1);
    check("rel3 b_nop", 32'(b_nop), 0);
    check("rel3 b_busy", 32'(b_busy), 8);
    idle(4);

    // Reset mid-flush, overriding hold and redirect
    cyc(i_addi(18, 0, 1), 1'b1);
    cyc(NOP, 1'b0, 1'b1);
    cyc(NOP, 1'b0, 1'b1, 1'b1, 1'b1);
    check("rstf b_nop", 32'(b_nop), 1);
    check("rstf b_busy", 32'(b_busy), 2);
    cyc(NOP, 1'b0);
    check("rst+1 b_nop", 32'(b_nop), 0);
    check("rst+1 b_busy", 32'(b_busy), 0);
    check("rst+1 a_busy", 32'(a_busy), 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
